// File: rtl/logIP_pkg.sv
// Shared types for the logIP capture path.
// Holds the readback state encoding used by mmu_ring.
package logIP_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, HOLD} mmu_ring_state_t;

endpackage

// File: rtl/ramif.sv
// Single-port sample RAM with a registered, enable-gated read port.
// q_o holds its value between reads; only q_o is reset, not the array.
module ramif #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [DEPTH-1:0] addr_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] mem [2**DEPTH];

    always_ff @(posedge clk_i) begin
        if (en_i && we_i) begin
            mem[addr_i] <= d_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            q_o <= '0;
        end else if (en_i && !we_i) begin
            q_o <= mem[addr_i];
        end
    end

endmodule

// File: rtl/mmu_ring.sv
// Circular sample buffer: wrap-around capture, newest-first streaming readback.
// Define MMU_OLDEST_FIRST_EN to stream the requested window oldest first instead.
module mmu_ring
    import logIP_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic             clk_i,
    input  logic             rst_in,
    input  logic             clr_i,
    input  logic             mem_wrt_i,
    input  logic [WIDTH-1:0] mem_i,
    input  logic             rd_start_i,
    input  logic [DEPTH:0]   rd_cnt_i,
    output logic [WIDTH-1:0] mem_o,
    output logic             mem_valid_o,
    input  logic             mem_ready_i,
    output logic             rd_busy_o,
    output logic [DEPTH:0]   fill_o,
    output logic             wrapped_o
);

    localparam logic [DEPTH:0] FULL = {1'b1, {DEPTH{1'b0}}};

    mmu_ring_state_t  state;
    logic [DEPTH-1:0] wr_ptr;
    logic [DEPTH-1:0] rd_ptr;
    logic [DEPTH:0]   remaining;
    logic [DEPTH:0]   fill;
    logic             wrapped;
    logic             valid;
    logic             busy;

    logic             wr_acc;
    logic             rd_go;
    logic             rd_issue;
    logic [DEPTH-1:0] wr_ptr_nxt;
    logic [DEPTH:0]   fill_nxt;
    logic [DEPTH:0]   rd_n;
    logic [DEPTH-1:0] rd_ptr_start;
    logic [DEPTH-1:0] rd_ptr_step;
    logic             ram_en;
    logic             ram_we;
    logic [DEPTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_q;

    // Writes are only accepted in IDLE; the read window is clamped to what the
    // buffer holds after a same-cycle write, so that sample is read first.
    always_comb begin
        wr_acc     = mem_wrt_i && (state == IDLE) && !clr_i;
        wr_ptr_nxt = wr_ptr + DEPTH'(wr_acc);
        fill_nxt   = (wr_acc && fill != FULL) ? fill + (DEPTH+1)'(1) : fill;
        rd_n       = (rd_cnt_i < fill_nxt) ? rd_cnt_i : fill_nxt;
        rd_go      = rd_start_i && (state == IDLE) && !clr_i && (rd_n != '0);
        rd_issue   = (state == ISSUE) && !clr_i;
        ram_en     = wr_acc || rd_issue;
        ram_we     = wr_acc;
        ram_addr   = (state == ISSUE) ? rd_ptr : wr_ptr;
`ifdef MMU_OLDEST_FIRST_EN
        rd_ptr_start = wr_ptr_nxt - rd_n[DEPTH-1:0];
        rd_ptr_step  = rd_ptr + DEPTH'(1);
`else
        rd_ptr_start = wr_ptr_nxt - DEPTH'(1);
        rd_ptr_step  = rd_ptr - DEPTH'(1);
`endif
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            fill      <= '0;
            wrapped   <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else if (clr_i) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            remaining <= '0;
            fill      <= '0;
            wrapped   <= 1'b0;
            valid     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wr_ptr <= wr_ptr_nxt;
                    fill   <= fill_nxt;
                    if (wr_acc && fill == FULL) begin
                        wrapped <= 1'b1;
                    end
                    if (rd_go) begin
                        rd_ptr    <= rd_ptr_start;
                        remaining <= rd_n;
                        state     <= ISSUE;
                        busy      <= 1'b1;
                    end
                end
                ISSUE: begin
                    rd_ptr    <= rd_ptr_step;
                    remaining <= remaining - (DEPTH+1)'(1);
                    state     <= HOLD;
                    valid     <= 1'b1;
                end
                HOLD: begin
                    if (mem_ready_i) begin
                        valid <= 1'b0;
                        if (remaining != '0) begin
                            state <= ISSUE;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    ramif #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) i_ramif (
        .clk_i (clk_i),
        .rst_in(rst_in),
        .en_i  (ram_en),
        .we_i  (ram_we),
        .addr_i(ram_addr),
        .d_i   (mem_i),
        .q_o   (ram_q)
    );

    assign mem_o       = ram_q;
    assign mem_valid_o = valid;
    assign rd_busy_o   = busy;
    assign fill_o      = fill;
    assign wrapped_o   = wrapped;

endmodule

// File: tb/tb_mmu_ring.sv
// Directed testbench for mmu_ring (DEPTH=3, WIDTH=8): per-cycle vector table
// plus hand-written backpressure, same-cycle, clear and async-reset sequences.
module tb_mmu_ring;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
`ifdef MMU_OLDEST_FIRST_EN
    localparam bit OLDEST = 1'b1;
`else
    localparam bit OLDEST = 1'b0;
`endif

    typedef struct {
        logic       wrt;
        logic [7:0] din;
        logic       start;
        logic [3:0] cnt;
        logic       ready;
        logic       clr;
        logic       expValid;
        logic       expBusy;
        logic [7:0] expMem;
        logic [3:0] expFill;
        logic       expWrapped;
    } vec_t;

    logic             clk;
    logic             rstN;
    logic             clr;
    logic             memWrt;
    logic [WIDTH-1:0] memIn;
    logic             rdStart;
    logic [DEPTH:0]   rdCnt;
    logic [WIDTH-1:0] memOut;
    logic             memValid;
    logic             memReady;
    logic             rdBusy;
    logic [DEPTH:0]   fill;
    logic             wrapped;

    int   compared   = 0;
    int   mismatched = 0;
    vec_t vecs[$];

    mmu_ring #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_in     (rstN),
        .clr_i      (clr),
        .mem_wrt_i  (memWrt),
        .mem_i      (memIn),
        .rd_start_i (rdStart),
        .rd_cnt_i   (rdCnt),
        .mem_o      (memOut),
        .mem_valid_o(memValid),
        .mem_ready_i(memReady),
        .rd_busy_o  (rdBusy),
        .fill_o     (fill),
        .wrapped_o  (wrapped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void addVec(logic wrt, logic [7:0] din, logic start, logic [3:0] cnt,
                                   logic ready, logic clrIn, logic ev, logic eb, logic [7:0] em,
                                   logic [3:0] ef, logic ew);
        vec_t v;
        v.wrt = wrt; v.din = din; v.start = start; v.cnt = cnt; v.ready = ready; v.clr = clrIn;
        v.expValid = ev; v.expBusy = eb; v.expMem = em; v.expFill = ef; v.expWrapped = ew;
        vecs.push_back(v);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one cycle of inputs at the falling edge; outputs are settled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic wrt, input logic [7:0] din, input logic start,
                                 input logic [3:0] cnt, input logic ready, input logic clrIn);
        @(negedge clk);
        memWrt = wrt; memIn = din; rdStart = start; rdCnt = cnt; memReady = ready; clr = clrIn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag, input logic ev, input logic eb, input logic [7:0] em,
                            input logic [3:0] ef, input logic ew);
        checkOutput({tag, ".valid"}, 32'(memValid), 32'(ev));
        checkOutput({tag, ".busy"}, 32'(rdBusy), 32'(eb));
        if (ev) checkOutput({tag, ".mem"}, 32'(memOut), 32'(em));
        checkOutput({tag, ".fill"}, 32'(fill), 32'(ef));
        checkOutput({tag, ".wrapped"}, 32'(wrapped), 32'(ew));
    endtask

    initial begin
        logic [7:0] exp8;

        rstN = 1'b0; clr = 1'b0; memWrt = 1'b0; memIn = '0; rdStart = 1'b0; rdCnt = '0; memReady = 1'b0;

        // Scenario 1: three writes, read two back with ready held high
        addVec(1, 8'h11, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0);
        addVec(1, 8'h22, 0, 0, 1, 0, 0, 0, 8'h00, 2, 0);
        addVec(1, 8'h33, 0, 0, 1, 0, 0, 0, 8'h00, 3, 0);
        addVec(0, 8'h00, 1, 2, 1, 0, 0, 1, 8'h00, 3, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 1, 1, OLDEST ? 8'h22 : 8'h33, 3, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h00, 3, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 1, 1, OLDEST ? 8'h33 : 8'h22, 3, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 3, 0);

        // Scenario 2: clear, overfill with 0x01..0x0A, read back all eight
        addVec(0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0);
        for (int i = 1; i <= 10; i++)
            addVec(1, 8'(i), 0, 0, 1, 0, 0, 0, 8'h00, (i < 8) ? 4'(i) : 4'd8, (i >= 9));
        addVec(0, 8'h00, 1, 8, 1, 0, 0, 1, 8'h00, 8, 1);
        for (int k = 0; k < 8; k++) begin
            addVec(0, 8'h00, 0, 0, 1, 0, 1, 1, OLDEST ? 8'(3 + k) : 8'(10 - k), 8, 1);
            addVec(0, 8'h00, 0, 0, 1, 0, 0, (k < 7), 8'h00, 8, 1);
        end

        // Scenario 3: request more than stored, then a zero-length request
        addVec(0, 8'h00, 0, 0, 1, 1, 0, 0, 8'h00, 0, 0);
        addVec(1, 8'hA1, 0, 0, 1, 0, 0, 0, 8'h00, 1, 0);
        addVec(1, 8'hA2, 0, 0, 1, 0, 0, 0, 8'h00, 2, 0);
        addVec(0, 8'h00, 1, 5, 1, 0, 0, 1, 8'h00, 2, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 1, 1, OLDEST ? 8'hA1 : 8'hA2, 2, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h00, 2, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 1, 1, OLDEST ? 8'hA2 : 8'hA1, 2, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 2, 0);
        addVec(0, 8'h00, 1, 0, 1, 0, 0, 0, 8'h00, 2, 0);
        addVec(0, 8'h00, 0, 0, 1, 0, 0, 0, 8'h00, 2, 0);

        #3;
        checkAll("reset", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        checkOutput("reset.mem", 32'(memOut), 32'h0);
        @(negedge clk);
        rstN = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].wrt, vecs[i].din, vecs[i].start, vecs[i].cnt, vecs[i].ready, vecs[i].clr);
            checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expBusy, vecs[i].expMem,
                     vecs[i].expFill, vecs[i].expWrapped);
        end

        // Backpressure: output held while ready is low; writes during busy are dropped
        applyStimulus(0, 8'h00, 1, 1, 0, 0);
        checkAll("bp.issue", 1'b0, 1'b1, 8'h00, 4'd2, 1'b0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        checkAll("bp.hold", 1'b1, 1'b1, 8'hA2, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 8'h55, 0, 0, 0, 0);
            checkAll($sformatf("bp.stall%0d", i), 1'b1, 1'b1, 8'hA2, 4'd2, 1'b0);
        end
        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        checkAll("bp.accept", 1'b0, 1'b0, 8'h00, 4'd2, 1'b0);

        // Same-cycle write and start: the new sample is the first read back
        applyStimulus(1, 8'h44, 1, 1, 1, 0);
        checkAll("same.issue", 1'b0, 1'b1, 8'h00, 4'd3, 1'b0);
        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        checkAll("same.hold", 1'b1, 1'b1, 8'h44, 4'd3, 1'b0);
        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        checkAll("same.done", 1'b0, 1'b0, 8'h00, 4'd3, 1'b0);

        // Clear in the middle of a readback of a wrapped buffer
        for (int i = 0; i < 9; i++) applyStimulus(1, 8'(8'h60 + i), 0, 0, 1, 0);
        checkAll("clr.filled", 1'b0, 1'b0, 8'h00, 4'd8, 1'b1);
        applyStimulus(0, 8'h00, 1, 3, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        exp8 = OLDEST ? 8'h66 : 8'h68;
        checkAll("clr.hold", 1'b1, 1'b1, exp8, 4'd8, 1'b1);
        applyStimulus(0, 8'h00, 0, 0, 0, 1);
        checkAll("clr.after", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        checkAll("clr.idle", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);

        // Asynchronous reset asserted mid-HOLD, away from any clock edge
        applyStimulus(1, 8'h77, 0, 0, 0, 0);
        applyStimulus(0, 8'h00, 1, 1, 0, 0);
        applyStimulus(0, 8'h00, 0, 0, 0, 0);
        checkAll("arst.hold", 1'b1, 1'b1, 8'h77, 4'd1, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checkAll("arst.now", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);
        checkOutput("arst.mem", 32'(memOut), 32'h0);
        @(negedge clk);
        rstN = 1'b1;
        applyStimulus(0, 8'h00, 0, 0, 1, 0);
        checkAll("arst.idle", 1'b0, 1'b0, 8'h00, 4'd0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
